// File: rtl/regbank_wr_arb_if.sv
// Bus bundle for the shared register-bank write arbiter: requester side
// (master) and arbiter side (slave).
interface regbank_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic                    HOLD;
    logic [NREQ-1:0]         REQ;
    logic [NREQ*AW-1:0]      ADDR;
    logic [NREQ*WIDTH-1:0]   WDATA;
    logic [NREQ-1:0]         ACK;
    logic                    GNT_VLD;
    logic [2:0]              GNT_ID;
    logic [AW-1:0]           RADDR;
    logic [WIDTH-1:0]        RDATA;
    logic [15:0]             WR_CNT;

    modport master (
        output HOLD, REQ, ADDR, WDATA, RADDR,
        input  ACK, GNT_VLD, GNT_ID, RDATA, WR_CNT
    );

    modport slave (
        input  HOLD, REQ, ADDR, WDATA, RADDR,
        output ACK, GNT_VLD, GNT_ID, RDATA, WR_CNT
    );
endinterface

// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter for a small clock-enabled register bank:
// one write per clock, registered one-hot ACK, registered read port.
module regbank_wr_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic              CLK,
    input logic              RESETN,
    regbank_wr_arb_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] bank [DEPTH];

    logic [2:0]       ptr_q;
    logic [NREQ-1:0]  ack_q;
    logic             gnt_vld_q;
    logic [2:0]       gnt_id_q;
    logic [WIDTH-1:0] rdata_q;
    logic [15:0]      wr_cnt_q;

    logic [NREQ-1:0]  eligible;
    logic             win_vld;
    logic [2:0]       win_id;
    logic             grant;
    logic [2:0]       ptr_nxt;
    logic [NREQ-1:0]  ack_d;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [DEPTH-1:0] word_ce;

    // Two-pass search: requesters at or above PTR first, then wrap to the
    // lowest eligible one; equivalent to a modulo scan starting at PTR.
    always_comb begin
        eligible = bus.REQ & ~ack_q;
        win_vld  = 1'b0;
        win_id   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && eligible[i] && (3'(i) >= ptr_q)) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_vld && eligible[i]) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
            end
        end
    end

    always_comb begin
        grant   = win_vld && !bus.HOLD;
        ptr_nxt = (win_id == 3'(NREQ - 1)) ? 3'd0 : win_id + 3'd1;
        ack_d   = '0;
        waddr   = '0;
        wdata   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_id == 3'(i)) begin
                ack_d[i] = grant;
                waddr    = bus.ADDR[i*AW +: AW];
                wdata    = bus.WDATA[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned j = 0; j < DEPTH; j++) begin
            word_ce[j] = grant && (waddr == AW'(j));
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!RESETN) begin
                bank[j] <= '0;
            end else if (word_ce[j]) begin
                bank[j] <= wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ptr_q     <= '0;
            ack_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            rdata_q   <= '0;
            wr_cnt_q  <= '0;
        end else begin
            rdata_q   <= bank[bus.RADDR];
            ack_q     <= ack_d;
            gnt_vld_q <= grant;
            gnt_id_q  <= grant ? win_id : 3'd0;
            if (grant) begin
                ptr_q    <= ptr_nxt;
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign bus.ACK     = ack_q;
    assign bus.GNT_VLD = gnt_vld_q;
    assign bus.GNT_ID  = gnt_id_q;
    assign bus.RDATA   = rdata_q;
    assign bus.WR_CNT  = wr_cnt_q;
endmodule

// File: tb/tb_regbank_wr_arb.sv
// Directed self-checking bench for regbank_wr_arb (NREQ=4, WIDTH=8, DEPTH=4).
module tb_regbank_wr_arb;
    logic CLK;
    logic RESETN;
    int   n_pass;
    int   n_fail;
    int   n_total;

    regbank_wr_arb_if #(.NREQ(4), .WIDTH(8), .DEPTH(4)) bus ();

    regbank_wr_arb #(.NREQ(4), .WIDTH(8), .DEPTH(4)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        bus.ADDR[i*2 +: 2]  = a;
        bus.WDATA[i*8 +: 8] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        RESETN    = 1'b0;
        bus.HOLD  = 1'b0;
        bus.REQ   = '0;
        bus.ADDR  = '0;
        bus.WDATA = '0;
        bus.RADDR = '0;
        tick();
        tick();
        chk("rst_ack", 32'(bus.ACK), 0);
        chk("rst_cnt", 32'(bus.WR_CNT), 0);
        RESETN = 1'b1;

        // single requester 2, word 3, held REQ -> one write every 2 cycles
        set_req(2, 2'd3, 8'hA5);
        bus.REQ   = 4'b0100;
        bus.RADDR = 2'd3;
        tick();
        chk("single_ack1", 32'(bus.ACK), 32'h4);
        chk("single_vld1", 32'(bus.GNT_VLD), 1);
        chk("single_id1", 32'(bus.GNT_ID), 2);
        chk("single_cnt1", 32'(bus.WR_CNT), 1);
        chk("single_rd_old", 32'(bus.RDATA), 0);
        tick();
        chk("single_ack2", 32'(bus.ACK), 0);
        chk("single_id2", 32'(bus.GNT_ID), 0);
        chk("single_rd_new", 32'(bus.RDATA), 32'hA5);
        chk("single_cnt2", 32'(bus.WR_CNT), 1);
        tick();
        chk("single_ack3", 32'(bus.ACK), 32'h4);
        chk("single_cnt3", 32'(bus.WR_CNT), 2);
        tick();
        chk("single_ack4", 32'(bus.ACK), 0);
        chk("single_cnt4", 32'(bus.WR_CNT), 2);

        // reset with all requesters pending: nothing written, everything cleared
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'hE0 + i));
        bus.REQ = 4'b1111;
        RESETN  = 1'b0;
        tick();
        chk("rst2_ack", 32'(bus.ACK), 0);
        chk("rst2_vld", 32'(bus.GNT_VLD), 0);
        chk("rst2_id", 32'(bus.GNT_ID), 0);
        chk("rst2_rdata", 32'(bus.RDATA), 0);
        chk("rst2_cnt", 32'(bus.WR_CNT), 0);
        bus.REQ = '0;
        RESETN  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            bus.RADDR = 2'(r);
            tick();
            chk("rst2_bank", 32'(bus.RDATA), 0);
        end

        // round robin with all four requesting
        for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h40 + i));
        bus.REQ = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_vld", 32'(bus.GNT_VLD), 1);
            chk("rr_id", 32'(bus.GNT_ID), 32'(k % 4));
            chk("rr_ack", 32'(bus.ACK), 32'(1 << (k % 4)));
        end
        bus.REQ = '0;
        tick();
        chk("rr_ack_idle", 32'(bus.ACK), 0);
        chk("rr_cnt", 32'(bus.WR_CNT), 8);
        for (int r = 0; r < 4; r++) begin
            bus.RADDR = 2'(r);
            tick();
            chk("rr_bank", 32'(bus.RDATA), 32'(8'h40 + r));
        end

        // collision on word 1, PTR=0: requester 0 first, then 1
        set_req(0, 2'd1, 8'h11);
        set_req(1, 2'd1, 8'h22);
        bus.REQ   = 4'b0011;
        bus.RADDR = 2'd1;
        tick();
        chk("col_ack0", 32'(bus.ACK), 32'h1);
        chk("col_rd0", 32'(bus.RDATA), 32'h41);
        tick();
        chk("col_ack1", 32'(bus.ACK), 32'h2);
        chk("col_id1", 32'(bus.GNT_ID), 1);
        chk("col_rd1", 32'(bus.RDATA), 32'h11);
        bus.REQ = '0;
        tick();
        chk("col_ack2", 32'(bus.ACK), 0);
        chk("col_rd2", 32'(bus.RDATA), 32'h22);
        chk("col_cnt", 32'(bus.WR_CNT), 10);

        // move PTR to 1, then HOLD for 3 cycles with REQ=0011
        set_req(0, 2'd0, 8'h55);
        bus.REQ = 4'b0001;
        tick();
        chk("pre_hold_ack", 32'(bus.ACK), 32'h1);
        chk("pre_hold_cnt", 32'(bus.WR_CNT), 11);
        set_req(0, 2'd0, 8'h33);
        set_req(1, 2'd2, 8'h44);
        bus.REQ   = 4'b0011;
        bus.HOLD  = 1'b1;
        bus.RADDR = 2'd0;
        #1;
        chk("hold_ack_kept", 32'(bus.ACK), 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold_ack", 32'(bus.ACK), 0);
            chk("hold_vld", 32'(bus.GNT_VLD), 0);
            chk("hold_cnt", 32'(bus.WR_CNT), 11);
            chk("hold_bank", 32'(bus.RDATA), 32'h55);
        end
        bus.HOLD = 1'b0;
        tick();
        chk("resume_ack", 32'(bus.ACK), 32'h2);
        chk("resume_id", 32'(bus.GNT_ID), 1);
        chk("resume_cnt", 32'(bus.WR_CNT), 12);
        tick();
        chk("rw_same_ack", 32'(bus.ACK), 32'h1);
        chk("rw_same_old", 32'(bus.RDATA), 32'h55);
        chk("rw_same_cnt", 32'(bus.WR_CNT), 13);
        bus.REQ = '0;
        tick();
        chk("rw_same_new", 32'(bus.RDATA), 32'h33);
        chk("rw_idle_ack", 32'(bus.ACK), 0);
        bus.RADDR = 2'd2;
        tick();
        chk("hold_w2", 32'(bus.RDATA), 32'h44);

        // WR_CNT wrap: 65535 writes, then one more
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        set_req(0, 2'd0, 8'h01);
        set_req(1, 2'd0, 8'h02);
        bus.REQ   = 4'b0011;
        bus.RADDR = 2'd0;
        repeat (65535) tick();
        chk("wrap_ffff", 32'(bus.WR_CNT), 32'hFFFF);
        chk("wrap_vld", 32'(bus.GNT_VLD), 1);
        chk("wrap_id0", 32'(bus.GNT_ID), 0);
        tick();
        chk("wrap_zero", 32'(bus.WR_CNT), 0);
        chk("wrap_id1", 32'(bus.GNT_ID), 1);
        chk("wrap_ack", 32'(bus.ACK), 32'h2);
        bus.REQ = '0;
        tick();
        chk("wrap_hold_cnt", 32'(bus.WR_CNT), 0);
        chk("wrap_idle_ack", 32'(bus.ACK), 0);
        chk("wrap_last_data", 32'(bus.RDATA), 32'h02);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
